// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline sequencer for a 5-stage RV32I core. It drives the stall and flush
//   enables of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the
//   select lines of the EX-stage forwarding muxes.
//
//   It detects load-use hazards and control hazards. It also tracks wait states
//   of a multi-cycle data memory, raises a sticky timeout flag, and counts the
//   cycles in which the front end is stalled.
//
// Ports
//   CLK, RST             clock (rising edge), asynchronous active-low reset
//   Rs1D, Rs2D           source registers in Decode
//   Rs1E, Rs2E           source registers in Execute
//   RdE, RdM, RdW        destination registers in Execute / Memory / WriteBack
//   ResultSrcE           result select of the Execute instruction
//   RegWriteM, RegWriteW register write enables in Memory / WriteBack
//   PCSrcE               taken branch or jump resolved in Execute
//   MemReqM, MemReadyM   data-memory request and ready handshake
//   ForwardAE/BE         SrcA/SrcB select: 00 regfile, 10 ALUResultM, 01 ResultW
//   StallF..FlushW       pipeline register hold/clear enables
//   MemTimeout           sticky flag: memory wait reached TIMEOUT cycles
//   StallCount           saturating count of cycles with StallF high
// ----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter logic [2:0] LOAD_SRC = 3'b001,
    parameter int         TIMEOUT  = 16,
    parameter int         CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [2:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             StallE,
    output logic             FlushE,
    output logic             StallM,
    output logic             FlushW,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t            state_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic              timeout_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    logic lw_stall;
    logic mem_stall;

    // Memory stage has priority over WriteBack because it holds the newer value.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && (RdM != 5'd0) && (RdM == rs)) begin
            return 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == rs)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    assign lw_stall  = (ResultSrcE == LOAD_SRC) && (RdE != 5'd0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));
    // A memory that is ready in the same cycle as the request never stalls.
    assign mem_stall = MemReqM && !MemReadyM;

    // Outputs are combinational so that a stall takes effect in the same cycle
    // that the hazard appears. Reset forces every enable low.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        StallE    = 1'b0;
        FlushE    = 1'b0;
        StallM    = 1'b0;
        FlushW    = 1'b0;
        if (RST) begin
            ForwardAE = fwd_sel(Rs1E);
            ForwardBE = fwd_sel(Rs2E);
            if (mem_stall) begin
                // The whole pipe freezes. A branch waiting in EX stays frozen
                // there and is flushed once the memory finishes.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                // A load-use stall on the wrong path is ignored; it is flushed anyway.
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    assign stall_cnt_d = (StallF && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

    // NOTE: sequential state uses non-blocking assignments and resets asynchronously.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            case (state_q)
                S_IDLE: begin
                    if (mem_stall) begin
                        state_q <= S_WAIT;
                        wcnt_q  <= '0;
                    end
                end
                S_WAIT: begin
                    // The counter stops at TIMEOUT. The flag stays set until reset,
                    // and the FSM keeps waiting for the memory.
                    if (wcnt_q != WCNT_MAX) begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                    if (wcnt_q == WCNT_LAST) begin
                        timeout_q <= 1'b1;
                    end
                    if (MemReadyM || !MemReqM) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign MemTimeout = timeout_q;
    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Scoreboard bench for hazard_ctrl. The stimulus process drives one vector
//   per cycle and queues the expected outputs, which are computed by hand.
//   The monitor process pops one entry at each falling edge and compares it
//   with the outputs of the DUT.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [2:0]  ResultSrcE;
    logic        RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW;
    logic        MemTimeout;
    logic [31:0] StallCount;

    hazard_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .ResultSrcE (ResultSrcE),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .PCSrcE     (PCSrcE),
        .MemReqM    (MemReqM),
        .MemReadyM  (MemReadyM),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .StallE     (StallE),
        .FlushE     (FlushE),
        .StallM     (StallM),
        .FlushW     (FlushW),
        .MemTimeout (MemTimeout),
        .StallCount (StallCount)
    );

    always #5 CLK = ~CLK;

    // Stall/flush group, bit order {StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW}
    localparam logic [6:0] ST_NONE = 7'b0000000;
    localparam logic [6:0] ST_MEM  = 7'b1101011;
    localparam logic [6:0] ST_BR   = 7'b0010100;
    localparam logic [6:0] ST_LW   = 7'b1100100;

    typedef struct packed {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [6:0]  stl;
        logic        to;
        logic [31:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;
    bit    stim_done = 1'b0;

    task automatic check(input string nm, input string fld,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%0h expected=%0h at %0t", nm, fld, act, exp, $time);
        end
    endtask

    // Queue the expected outputs for the current cycle, then move to the next cycle.
    task automatic cyc(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [6:0] stl, input logic to, input logic [31:0] cnt);
        exp_t e;
        e.fa  = fa;
        e.fb  = fb;
        e.stl = stl;
        e.to  = to;
        e.cnt = cnt;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
        RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 3'b000;
        RegWriteM = 0; RegWriteW = 0;
        PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    // Monitor: sample the outputs at the falling edge, away from the active edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, "ForwardAE",  32'(ForwardAE),  32'(e.fa));
                check(nm, "ForwardBE",  32'(ForwardBE),  32'(e.fb));
                check(nm, "StallF",     32'(StallF),     32'(e.stl[6]));
                check(nm, "StallD",     32'(StallD),     32'(e.stl[5]));
                check(nm, "FlushD",     32'(FlushD),     32'(e.stl[4]));
                check(nm, "StallE",     32'(StallE),     32'(e.stl[3]));
                check(nm, "FlushE",     32'(FlushE),     32'(e.stl[2]));
                check(nm, "StallM",     32'(StallM),     32'(e.stl[1]));
                check(nm, "FlushW",     32'(FlushW),     32'(e.stl[0]));
                check(nm, "MemTimeout", 32'(MemTimeout), 32'(e.to));
                check(nm, "StallCount", StallCount,      e.cnt);
            end
        end
    end

    // Stimulus
    initial begin
        clear_inputs();
        RST = 1'b0;
        // T1: hold reset while a memory stall and a branch are requested.
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        Rs1E = 5; RdM = 5; RegWriteM = 1;
        @(posedge CLK);
        #1;
        cyc("rst_hold",  2'b00, 2'b00, ST_NONE, 1'b0, 0);
        cyc("rst_hold2", 2'b00, 2'b00, ST_NONE, 1'b0, 0);
        clear_inputs();
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        RST = 1'b1;
        cyc("rst_release", 2'b00, 2'b00, ST_MEM, 1'b0, 0);
        MemReadyM = 1;
        cyc("wait_exit_br", 2'b00, 2'b00, ST_BR, 1'b0, 1);
        clear_inputs();
        cyc("post_rst_idle", 2'b00, 2'b00, ST_NONE, 1'b0, 1);

        // T2: forwarding
        Rs1E = 5; Rs2E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        cyc("fwd_m_wins", 2'b10, 2'b10, ST_NONE, 1'b0, 1);
        RdM = 0;
        cyc("fwd_rdm_zero", 2'b01, 2'b01, ST_NONE, 1'b0, 1);
        Rs2E = 0; RdW = 0;
        cyc("fwd_none", 2'b00, 2'b00, ST_NONE, 1'b0, 1);
        RdM = 5; RegWriteM = 0; RdW = 5; RegWriteW = 1; Rs2E = 3;
        cyc("fwd_m_nowrite", 2'b01, 2'b00, ST_NONE, 1'b0, 1);
        RdM = 3; RegWriteM = 1;
        cyc("fwd_split", 2'b01, 2'b10, ST_NONE, 1'b0, 1);
        clear_inputs();

        // T3: load-use
        ResultSrcE = 3'b001; RdE = 7; Rs2D = 7;
        cyc("lw_stall", 2'b00, 2'b00, ST_LW, 1'b0, 1);
        clear_inputs();
        cyc("lw_done", 2'b00, 2'b00, ST_NONE, 1'b0, 2);
        ResultSrcE = 3'b001; RdE = 7; Rs1D = 7; PCSrcE = 1;
        cyc("lw_with_branch", 2'b00, 2'b00, ST_BR, 1'b0, 2);
        PCSrcE = 0; ResultSrcE = 3'b010;
        cyc("not_load", 2'b00, 2'b00, ST_NONE, 1'b0, 2);
        ResultSrcE = 3'b001; RdE = 0; Rs1D = 0;
        cyc("load_rd_zero", 2'b00, 2'b00, ST_NONE, 1'b0, 2);
        clear_inputs();

        // T4: memory wait of three cycles, then ready
        MemReqM = 1; MemReadyM = 0;
        cyc("mem_w0", 2'b00, 2'b00, ST_MEM, 1'b0, 2);
        cyc("mem_w1", 2'b00, 2'b00, ST_MEM, 1'b0, 3);
        cyc("mem_w2", 2'b00, 2'b00, ST_MEM, 1'b0, 4);
        MemReadyM = 1;
        cyc("mem_ready", 2'b00, 2'b00, ST_NONE, 1'b0, 5);
        MemReqM = 0;
        cyc("ready_no_req", 2'b00, 2'b00, ST_NONE, 1'b0, 5);
        MemReqM = 1;
        cyc("zero_wait", 2'b00, 2'b00, ST_NONE, 1'b0, 5);
        clear_inputs();
        cyc("mem_idle", 2'b00, 2'b00, ST_NONE, 1'b0, 5);

        // T6: branch held during a memory wait
        PCSrcE = 1; MemReqM = 1; MemReadyM = 0;
        cyc("br_wait0", 2'b00, 2'b00, ST_MEM, 1'b0, 5);
        cyc("br_wait1", 2'b00, 2'b00, ST_MEM, 1'b0, 6);
        MemReadyM = 1;
        cyc("br_after_wait", 2'b00, 2'b00, ST_BR, 1'b0, 7);
        clear_inputs();
        cyc("br_idle", 2'b00, 2'b00, ST_NONE, 1'b0, 7);

        // T5: timeout. Cycle 0 is in IDLE and cycles 1..19 are WAIT cycles.
        // The flag is set at the edge that ends WAIT cycle 16.
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 20; i++) begin
            cyc("to_wait", 2'b00, 2'b00, ST_MEM, (i >= 17), 32'(7 + i));
        end
        MemReadyM = 1;
        cyc("to_ready", 2'b00, 2'b00, ST_NONE, 1'b1, 27);
        clear_inputs();
        cyc("to_sticky", 2'b00, 2'b00, ST_NONE, 1'b1, 27);

        // Asynchronous reset in the middle of a wait
        MemReqM = 1; MemReadyM = 0;
        cyc("rw0", 2'b00, 2'b00, ST_MEM, 1'b1, 27);
        cyc("rw1", 2'b00, 2'b00, ST_MEM, 1'b1, 28);
        RST = 1'b0;
        cyc("rst_mid_wait", 2'b00, 2'b00, ST_NONE, 1'b0, 0);
        RST = 1'b1;
        cyc("rst_rel_wait", 2'b00, 2'b00, ST_MEM, 1'b0, 0);
        MemReadyM = 1;
        cyc("rst_rel_ready", 2'b00, 2'b00, ST_NONE, 1'b0, 1);
        clear_inputs();
        cyc("final_idle", 2'b00, 2'b00, ST_NONE, 1'b0, 1);

        // Let the monitor drain the queue, then check that nothing is left.
        @(posedge CLK);
        @(posedge CLK);
        check("drain", "queue_left", 32'(exp_q.size()), 32'd0);
        stim_done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
